// File: rtl/riscv_memory_pkg.sv
// riscv_memory_pkg
//   Shared definitions for the RV32I memory stage: data width, load funct3
//   encodings, result-source encoding, memory-stage FSM states and the
//   alignment helper used when RISCV_MISALIGN_CHK_EN is defined.
//   No ports (package).
package riscv_memory_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RSP  = 2'b10
    } memState_t;

    // funct3[1:0] carries the access size for both loads and stores
    // (00 byte, 01 half, 10 word).
    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLow);
        return ((funct3[1:0] == 2'b01) && addrLow[0]) ||
               ((funct3[1:0] == 2'b10) && (addrLow != 2'b00));
    endfunction

endpackage

// File: rtl/riscv_memory_load_extend.sv
// riscv_memory_load_extend
//   Combinational load formatting: shifts the bus word so the addressed byte
//   lands in lane 0, then sign- or zero-extends according to funct3.
// Ports
//   funct3   in   3     load funct3 (LB/LH/LW/LBU/LHU)
//   addrLow  in   2     byte offset within the word
//   word     in   XLEN  raw 32-bit word from the data bus
//   data     out  XLEN  extended load value
module riscv_memory_load_extend
    import riscv_memory_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addrLow,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = word >> {addrLow, 3'b000};
        data    = shifted;
        case (funct3)
            FUNCT3_LB:  data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            FUNCT3_LH:  data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            FUNCT3_LW:  data = shifted;
            FUNCT3_LBU: data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            FUNCT3_LHU: data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default:    data = shifted;
        endcase
    end

endmodule

// File: rtl/riscv_memory.sv
// riscv_memory
//   Memory stage of the pipelined RV32I core. Registers the execute-stage
//   outputs (E->M), runs the req/gnt/rvalid data-bus handshake, lane-aligns
//   store data/byte enables and formats load data. Stalls the front of the
//   pipe while a bus access is outstanding.
//   Optional macro RISCV_MISALIGN_CHK_EN: misaligned half/word accesses are
//   not issued; they raise o_misalign_excM and suppress the rd write.
// Ports
//   i_clk, i_rstn                  clock, async active-low reset
//   i_ctrl_*E, i_regfile_rd_addrE  execute-stage control inputs
//   i_alu_resultE                  effective address / ALU result
//   i_mem_writedataE, i_PCPlus4E   store data, link value
//   o_ctrl_*M, o_regfile_rd_addrM  registered control to W / hazard unit
//   o_alu_resultM, o_PCPlus4M      registered data to W / forwarding
//   o_mem_readdataM                extended load data
//   o_hazard_stallM                freeze F/D/E and the E->M register
//   o_misalign_excM                misaligned access flag
//   o_dmem_*, i_dmem_*             data-memory bus
//
// FSM
//   state | meaning
//   IDLE  | no access outstanding (non-mem op or empty M)
//   REQ   | request driven, waiting for gnt
//   RSP   | load granted, waiting for rvalid
module riscv_memory
    import riscv_memory_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_ctrl_reg_wr_enE,
    input  logic [1:0]      i_ctrl_result_srcE,
    input  logic            i_ctrl_mem_wr_enE,
    input  logic [3:0]      i_ctrl_mem_byte_selE,
    input  logic [2:0]      i_ctrl_funct3E,
    input  logic [4:0]      i_regfile_rd_addrE,
    input  logic [XLEN-1:0] i_alu_resultE,
    input  logic [XLEN-1:0] i_mem_writedataE,
    input  logic [XLEN-1:0] i_PCPlus4E,
    output logic            o_ctrl_reg_wr_enM,
    output logic [1:0]      o_ctrl_result_srcM,
    output logic [4:0]      o_regfile_rd_addrM,
    output logic [XLEN-1:0] o_alu_resultM,
    output logic [XLEN-1:0] o_PCPlus4M,
    output logic [XLEN-1:0] o_mem_readdataM,
    output logic            o_hazard_stallM,
    output logic            o_misalign_excM,
    output logic            o_dmem_req,
    output logic            o_dmem_wr,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata
);

    logic            regWrEnM;
    logic [1:0]      resultSrcM;
    logic            memWrEnM;
    logic [3:0]      byteSelM;
    logic [2:0]      funct3M;
    logic [4:0]      rdAddrM;
    logic [XLEN-1:0] aluResultM;
    logic [XLEN-1:0] writeDataM;
    logic [XLEN-1:0] pcPlus4M;
    logic [XLEN-1:0] heldRdata;
    logic [XLEN-1:0] loadWord;

    memState_t state;
    memState_t stateNext;

    logic stall;
    logic memOpE;
    logic startE;
    logic loadM;
    logic misalignM;
    logic rvalidInRsp;

    assign memOpE = (i_ctrl_result_srcE == RESULT_SRC_LOAD) || i_ctrl_mem_wr_enE;
    assign loadM  = (resultSrcM == RESULT_SRC_LOAD);

`ifdef RISCV_MISALIGN_CHK_EN
    // A misaligned op still enters M (so it can raise the flag) but never
    // starts a bus access.
    assign startE    = memOpE && !isMisaligned(i_ctrl_funct3E, i_alu_resultE[1:0]);
    assign misalignM = (loadM || memWrEnM) && isMisaligned(funct3M, aluResultM[1:0]);
`else
    assign startE    = memOpE;
    assign misalignM = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            regWrEnM   <= 1'b0;
            resultSrcM <= 2'b00;
            memWrEnM   <= 1'b0;
            byteSelM   <= 4'b0000;
            funct3M    <= 3'b000;
            rdAddrM    <= 5'd0;
            aluResultM <= '0;
            writeDataM <= '0;
            pcPlus4M   <= '0;
        end else if (!stall) begin
            regWrEnM   <= i_ctrl_reg_wr_enE;
            resultSrcM <= i_ctrl_result_srcE;
            memWrEnM   <= i_ctrl_mem_wr_enE;
            byteSelM   <= i_ctrl_mem_byte_selE;
            funct3M    <= i_ctrl_funct3E;
            rdAddrM    <= i_regfile_rd_addrE;
            aluResultM <= i_alu_resultE;
            writeDataM <= i_mem_writedataE;
            pcPlus4M   <= i_PCPlus4E;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Whenever the stall drops, the E->M register reloads, so the next state
    // is decided by the op entering M. This gives back-to-back accesses
    // without an idle bubble.
    always_comb begin
        stall     = 1'b0;
        stateNext = state;
        case (state)
            REQ: begin
                stall = !(i_dmem_gnt && memWrEnM) || loadM;
                if (i_dmem_gnt && !memWrEnM) begin
                    stateNext = RSP;
                end
            end
            RSP: begin
                stall = !i_dmem_rvalid;
            end
            default: begin
            end
        endcase
        if (!stall) begin
            stateNext = startE ? REQ : IDLE;
        end
    end

    // rvalid only counts while a load is waiting for it; a stray or late
    // beat (e.g. after a reset mid-access) leaves the held copy untouched.
    assign rvalidInRsp = (state == RSP) && i_dmem_rvalid;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            heldRdata <= '0;
        end else if (rvalidInRsp) begin
            heldRdata <= i_dmem_rdata;
        end
    end

    assign loadWord = rvalidInRsp ? i_dmem_rdata : heldRdata;

    riscv_memory_load_extend uLoadExtend (
        .funct3  (funct3M),
        .addrLow (aluResultM[1:0]),
        .word    (loadWord),
        .data    (o_mem_readdataM)
    );

    // Bus fields come straight from the M register, which is frozen while
    // stalled, so they stay stable from REQ entry until gnt.
    assign o_dmem_req   = (state == REQ);
    assign o_dmem_wr    = memWrEnM;
    assign o_dmem_addr  = {aluResultM[XLEN-1:2], 2'b00};
    assign o_dmem_be    = byteSelM << aluResultM[1:0];
    assign o_dmem_wdata = writeDataM << {aluResultM[1:0], 3'b000};

    assign o_ctrl_reg_wr_enM  = regWrEnM && !misalignM;
    assign o_ctrl_result_srcM = resultSrcM;
    assign o_regfile_rd_addrM = rdAddrM;
    assign o_alu_resultM      = aluResultM;
    assign o_PCPlus4M         = pcPlus4M;
    assign o_hazard_stallM    = stall;
    assign o_misalign_excM    = misalignM;

endmodule

// File: tb/tb_riscv_memory.sv
// tb_riscv_memory
//   Directed bench for riscv_memory: stores, loads with sign/zero extension,
//   wait-state handshakes, back-to-back accesses and reset mid-access.
//   Expected bus requests and load results are queued when an op is driven
//   and popped when the DUT presents them.
module tb_riscv_memory;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } busReq_t;

    logic        clk;
    logic        rstn;
    logic        regWrE;
    logic [1:0]  resSrcE;
    logic        memWrE;
    logic [3:0]  byteSelE;
    logic [2:0]  funct3E;
    logic [4:0]  rdE;
    logic [31:0] aluE;
    logic [31:0] wdataE;
    logic [31:0] pc4E;
    logic        regWrM;
    logic [1:0]  resSrcM;
    logic [4:0]  rdM;
    logic [31:0] aluM;
    logic [31:0] pc4M;
    logic [31:0] readDataM;
    logic        stallM;
    logic        excM;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    busReq_t     expReq[$];
    logic [31:0] expRdata[$];

    int nVectors;
    int nMiscompares;
    int stallCount;

    riscv_memory dut (
        .i_clk                (clk),
        .i_rstn               (rstn),
        .i_ctrl_reg_wr_enE    (regWrE),
        .i_ctrl_result_srcE   (resSrcE),
        .i_ctrl_mem_wr_enE    (memWrE),
        .i_ctrl_mem_byte_selE (byteSelE),
        .i_ctrl_funct3E       (funct3E),
        .i_regfile_rd_addrE   (rdE),
        .i_alu_resultE        (aluE),
        .i_mem_writedataE     (wdataE),
        .i_PCPlus4E           (pc4E),
        .o_ctrl_reg_wr_enM    (regWrM),
        .o_ctrl_result_srcM   (resSrcM),
        .o_regfile_rd_addrM   (rdM),
        .o_alu_resultM        (aluM),
        .o_PCPlus4M           (pc4M),
        .o_mem_readdataM      (readDataM),
        .o_hazard_stallM      (stallM),
        .o_misalign_excM      (excM),
        .o_dmem_req           (req),
        .o_dmem_wr            (wr),
        .o_dmem_addr          (addr),
        .o_dmem_be            (be),
        .o_dmem_wdata         (wdata),
        .i_dmem_gnt           (gnt),
        .i_dmem_rvalid        (rvalid),
        .i_dmem_rdata         (rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic driveE(input logic rw, input logic [1:0] rs, input logic mw, input logic [3:0] bs,
                          input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [31:0] pc4);
        regWrE   = rw;
        resSrcE  = rs;
        memWrE   = mw;
        byteSelE = bs;
        funct3E  = f3;
        rdE      = rd;
        aluE     = alu;
        wdataE   = wd;
        pc4E     = pc4;
    endtask

    task automatic driveNop();
        driveE(1'b0, 2'b00, 1'b0, 4'b0000, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic checkReq(input string tag);
        busReq_t e;
        check({tag, "_sb_req_pending"}, 32'(expReq.size() != 0), 32'd1);
        if (expReq.size() != 0) begin
            e = expReq.pop_front();
            check({tag, "_req"}, 32'(req), 32'd1);
            check({tag, "_wr"}, 32'(wr), 32'(e.wr));
            check({tag, "_addr"}, addr, e.addr);
            check({tag, "_be"}, 32'(be), 32'(e.be));
            check({tag, "_wdata"}, wdata, e.wdata);
        end
    endtask

    task automatic checkRdata(input string tag);
        logic [31:0] e;
        check({tag, "_sb_rdata_pending"}, 32'(expRdata.size() != 0), 32'd1);
        if (expRdata.size() != 0) begin
            e = expRdata.pop_front();
            check({tag, "_readdata"}, readDataM, e);
        end
    endtask

    // Store with an immediate grant: one cycle in M, never stalls.
    task automatic doStore(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] bs, input logic [2:0] f3,
                           input logic [31:0] expAddr, input logic [3:0] expBe, input logic [31:0] expWdata);
        driveE(1'b0, 2'b00, 1'b1, bs, f3, 5'd0, a, d, a + 32'd4);
        expReq.push_back('{wr: 1'b1, addr: expAddr, be: expBe, wdata: expWdata});
        step();
        driveNop();
        gnt = 1'b1;
        settle();
        checkReq(tag);
        check({tag, "_stall"}, 32'(stallM), 32'd0);
        check({tag, "_exc"}, 32'(excM), 32'd0);
        step();
        gnt = 1'b0;
        settle();
        check({tag, "_req_dropped"}, 32'(req), 32'd0);
    endtask

    // Load with zero wait states: gnt in the first M cycle, rvalid in the second.
    task automatic doLoad(input string tag, input logic [31:0] a, input logic [2:0] f3, input logic [3:0] bs,
                          input logic [31:0] word, input logic [31:0] expAddr, input logic [3:0] expBe,
                          input logic [31:0] expData);
        driveE(1'b1, 2'b01, 1'b0, bs, f3, 5'd7, a, 32'h0, a + 32'd4);
        expReq.push_back('{wr: 1'b0, addr: expAddr, be: expBe, wdata: 32'h0});
        expRdata.push_back(expData);
        step();
        driveNop();
        gnt = 1'b1;
        settle();
        checkReq(tag);
        check({tag, "_stall_c1"}, 32'(stallM), 32'd1);
        step();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = word;
        settle();
        check({tag, "_stall_c2"}, 32'(stallM), 32'd0);
        check({tag, "_rd"}, 32'(rdM), 32'd7);
        checkRdata(tag);
        step();
        rvalid = 1'b0;
        rdata  = 32'h0;
        settle();
        check({tag, "_req_after"}, 32'(req), 32'd0);
        check({tag, "_stall_after"}, 32'(stallM), 32'd0);
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        stallCount   = 0;
        rstn   = 1'b1;
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = 32'h0;
        driveNop();

        // Reset state
        #2 rstn = 1'b0;
        step();
        step();
        settle();
        check("rst_req", 32'(req), 32'd0);
        check("rst_stall", 32'(stallM), 32'd0);
        check("rst_exc", 32'(excM), 32'd0);
        check("rst_regwr", 32'(regWrM), 32'd0);
        check("rst_alu", aluM, 32'h0);
        check("rst_readdata", readDataM, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_be", 32'(be), 32'd0);
        check("rst_wdata", wdata, 32'h0);

        step();
        rstn = 1'b1;

        // Non-mem op: registered pass-through, no stall, no request
        driveE(1'b1, 2'b00, 1'b0, 4'b0000, 3'b000, 5'd5, 32'h1234_5678, 32'h0, 32'h0000_1004);
        step();
        driveNop();
        settle();
        check("alu_result", aluM, 32'h1234_5678);
        check("alu_rd", 32'(rdM), 32'd5);
        check("alu_regwr", 32'(regWrM), 32'd1);
        check("alu_pc4", pc4M, 32'h0000_1004);
        check("alu_srcM", 32'(resSrcM), 32'd0);
        check("alu_req", 32'(req), 32'd0);
        check("alu_stall", 32'(stallM), 32'd0);

        // Stores
        doStore("sw", 32'h100, 32'hDEAD_BEEF, 4'b1111, 3'b010, 32'h100, 4'b1111, 32'hDEAD_BEEF);
        doStore("sb", 32'h103, 32'h0000_00A5, 4'b0001, 3'b000, 32'h100, 4'b1000, 32'hA500_0000);
        doStore("sh", 32'h106, 32'h0000_BEEF, 4'b0011, 3'b001, 32'h104, 4'b1100, 32'hBEEF_0000);

        // Loads with extension
        doLoad("lb",  32'h102, 3'b000, 4'b0001, 32'h0080_0000, 32'h100, 4'b0100, 32'hFFFF_FF80);
        doLoad("lbu", 32'h102, 3'b100, 4'b0001, 32'h0080_0000, 32'h100, 4'b0100, 32'h0000_0080);
        doLoad("lb_pos", 32'h101, 3'b000, 4'b0001, 32'h0000_7F00, 32'h100, 4'b0010, 32'h0000_007F);
        doLoad("lh",  32'h102, 3'b001, 4'b0011, 32'h8001_0000, 32'h100, 4'b1100, 32'hFFFF_8001);
        doLoad("lhu", 32'h102, 3'b101, 4'b0011, 32'h8001_0000, 32'h100, 4'b1100, 32'h0000_8001);
        doLoad("lw",  32'h100, 3'b010, 4'b1111, 32'h89AB_CDEF, 32'h100, 4'b1111, 32'h89AB_CDEF);

        // LW: gnt after 3 wait cycles, rvalid 2 cycles after gnt
        driveE(1'b1, 2'b01, 1'b0, 4'b1111, 3'b010, 5'd9, 32'h200, 32'h0, 32'h204);
        expReq.push_back('{wr: 1'b0, addr: 32'h200, be: 4'b1111, wdata: 32'h0});
        expRdata.push_back(32'hCAFE_F00D);
        step();
        driveE(1'b1, 2'b00, 1'b0, 4'b0000, 3'b000, 5'd3, 32'h0000_AAAA, 32'h0, 32'h44);
        for (int i = 1; i <= 6; i++) begin
            gnt    = (i == 4);
            rvalid = (i == 6);
            rdata  = (i == 6) ? 32'hCAFE_F00D : 32'h5555_5555;
            settle();
            if (i == 1) checkReq("lw_wait");
            check("lw_wait_req", 32'(req), 32'(i <= 4));
            check("lw_wait_stall", 32'(stallM), 32'(i <= 5));
            check("lw_wait_addr", addr, 32'h200);
            check("lw_wait_rd_held", 32'(rdM), 32'd9);
            if (stallM) stallCount++;
            if (i == 6) checkRdata("lw_wait");
            step();
        end
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = 32'h0;
        settle();
        check("lw_wait_stall_cycles", 32'(stallCount), 32'd5);
        check("lw_wait_next_alu", aluM, 32'h0000_AAAA);
        check("lw_wait_next_rd", 32'(rdM), 32'd3);
        check("lw_wait_next_req", 32'(req), 32'd0);

        // Back-to-back LW then SW
        driveE(1'b1, 2'b01, 1'b0, 4'b1111, 3'b010, 5'd10, 32'h300, 32'h0, 32'h304);
        expReq.push_back('{wr: 1'b0, addr: 32'h300, be: 4'b1111, wdata: 32'h0});
        expRdata.push_back(32'h1111_2222);
        step();
        driveE(1'b0, 2'b00, 1'b1, 4'b1111, 3'b010, 5'd0, 32'h304, 32'h0102_0304, 32'h308);
        expReq.push_back('{wr: 1'b1, addr: 32'h304, be: 4'b1111, wdata: 32'h0102_0304});
        gnt = 1'b1;
        settle();
        checkReq("b2b_lw");
        check("b2b_lw_stall", 32'(stallM), 32'd1);
        step();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h1111_2222;
        settle();
        check("b2b_lw_rsp_stall", 32'(stallM), 32'd0);
        checkRdata("b2b_lw");
        step();
        driveNop();
        rvalid = 1'b0;
        rdata  = 32'h0;
        gnt    = 1'b1;
        settle();
        checkReq("b2b_sw");
        check("b2b_sw_stall", 32'(stallM), 32'd0);
        step();
        gnt = 1'b0;
        settle();
        check("b2b_idle_req", 32'(req), 32'd0);

        // Misaligned word store
`ifdef RISCV_MISALIGN_CHK_EN
        driveE(1'b0, 2'b00, 1'b1, 4'b1111, 3'b010, 5'd0, 32'h102, 32'h1122_3344, 32'h106);
        step();
        driveE(1'b1, 2'b01, 1'b0, 4'b0011, 3'b001, 5'd4, 32'h201, 32'h0, 32'h205);
        settle();
        check("mis_sw_req", 32'(req), 32'd0);
        check("mis_sw_exc", 32'(excM), 32'd1);
        check("mis_sw_stall", 32'(stallM), 32'd0);
        step();
        driveNop();
        settle();
        check("mis_lh_req", 32'(req), 32'd0);
        check("mis_lh_exc", 32'(excM), 32'd1);
        check("mis_lh_regwr", 32'(regWrM), 32'd0);
        step();
        settle();
        check("mis_clear_exc", 32'(excM), 32'd0);
`else
        doStore("mis_sw", 32'h102, 32'h1122_3344, 4'b1111, 3'b010, 32'h100, 4'b1100, 32'h3344_0000);
`endif

        // Reset while waiting in RSP; a late rvalid must be ignored
        driveE(1'b1, 2'b01, 1'b0, 4'b1111, 3'b010, 5'd12, 32'h400, 32'h0, 32'h404);
        expReq.push_back('{wr: 1'b0, addr: 32'h400, be: 4'b1111, wdata: 32'h0});
        step();
        driveNop();
        gnt = 1'b1;
        settle();
        checkReq("rst_rsp");
        step();
        gnt = 1'b0;
        settle();
        check("rst_rsp_waiting", 32'(stallM), 32'd1);
        #1 rstn = 1'b0;
        #1;
        check("rst_rsp_req", 32'(req), 32'd0);
        check("rst_rsp_stall", 32'(stallM), 32'd0);
        check("rst_rsp_alu", aluM, 32'h0);
        step();
        rstn   = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hFFFF_FFFF;
        settle();
        check("late_rvalid_readdata", readDataM, 32'h0);
        check("late_rvalid_stall", 32'(stallM), 32'd0);
        check("late_rvalid_req", 32'(req), 32'd0);
        step();
        rvalid = 1'b0;
        rdata  = 32'h0;
        settle();
        check("late_rvalid_held", readDataM, 32'h0);

        check("sb_req_drained", 32'(expReq.size()), 32'd0);
        check("sb_rdata_drained", 32'(expRdata.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
